// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, parity modes
// and parameter legality checks.
package uart_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int OVERSAMPLE_MIN = 4;
    localparam int OVERSAMPLE_MAX = 64;
    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 8;

    function automatic bit oversample_ok(input int os);
        return (os >= OVERSAMPLE_MIN) && (os <= OVERSAMPLE_MAX) && ((os % 2) == 0);
    endfunction

    function automatic bit data_bits_ok(input int db);
        return (db >= DATA_BITS_MIN) && (db <= DATA_BITS_MAX);
    endfunction

    function automatic bit stop_bits_ok(input int sb);
        return (sb == 1) || (sb == 2);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RST_VAL so the output never shows a spurious edge out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= {2{RST_VAL}};
        else        ff_q <= ff_d;
    end

    assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling on sample_tick, optional parity,
// 1 or 2 stop bits, valid/ready output with framing/parity/overrun flags.
module uart_rx_os
    import uart_defs_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    if (!oversample_ok(OVERSAMPLE)) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and in 4..64");
    end
    if (!data_bits_ok(DATA_BITS)) begin : g_bad_db
        $error("uart_rx_os: DATA_BITS must be in 5..8");
    end
    if (!stop_bits_ok(STOP_BITS)) begin : g_bad_sb
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    logic rxs;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rxs)
    );

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 commit;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    // Frame FSM: every decision happens on a tick; mid-bit sample points sit
    // OVERSAMPLE/2 ticks after the detected falling edge, then every OVERSAMPLE.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        commit  = 1'b0;
        if (sample_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (rxs) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                            stop_d  = 1'b0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    if (tick_q != TICK_LAST) begin
                        tick_d = tick_q + 1'b1;
                    end else begin
                        tick_d = '0;
                        if (state_q == ST_DATA) begin
                            shift_d[bit_q] = rxs;
                            if (bit_q == BIT_LAST)
                                state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            else
                                bit_d = bit_q + 1'b1;
                        end else if (state_q == ST_PARITY) begin
                            perr_d  = ((^shift_q) ^ rxs) != PAR_MODE;
                            state_d = ST_STOP;
                        end else begin
                            if (!rxs) ferr_d = 1'b1;
                            // Commit at the last stop mid-sample so a following
                            // start bit in the stop bit's second half is caught.
                            if (stop_q == STOP_LAST) begin
                                commit  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                stop_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = ferr_d;
                parity_err_d = perr_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (8N1, 8E1, 5N2) fed with
// hand-built serial frames; sample_tick every 4 clocks, 16x oversampling.
module tb_uart_rx_os;

    localparam int OS      = 16;
    localparam int TDIV    = 4;
    localparam int BIT_CLK = OS * TDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic [1:0] tcnt = 2'd0;
    logic [2:0] rx_line = 3'b111;
    logic       rdy0 = 1'b1;

    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic       v0, fe0, pe0, ov0;
    logic       v1, fe1, pe1, ov1;
    logic       v2, fe2, pe2, ov2;

    int n_chk = 0;
    int n_bad = 0;

    int         acc0 = 0, vcyc0 = 0, ovc0 = 0, acc1 = 0, acc2 = 0;
    logic [7:0] ld0 = '0, ld1 = '0;
    logic [4:0] ld2 = '0;
    logic       lfe0 = 0, lpe0 = 0, lpe1 = 0, lfe2 = 0, lpe2 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt        <= tcnt + 2'd1;
        sample_tick <= (tcnt == 2'd3);
    end

    uart_rx_os u_dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_in(rx_line[0]),
        .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_in(rx_line[1]),
        .rx_data(d1), .rx_valid(v1), .rx_ready(1'b1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    uart_rx_os #(.DATA_BITS(5), .STOP_BITS(2)) u_5b (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_in(rx_line[2]),
        .rx_data(d2), .rx_valid(v2), .rx_ready(1'b1),
        .frame_err(fe2), .parity_err(pe2), .overrun(ov2)
    );

    // Handshake monitors: log every accepted word and count valid/overrun cycles.
    always @(negedge clk) begin
        if (v0) vcyc0 <= vcyc0 + 1;
        if (ov0) ovc0 <= ovc0 + 1;
        if (v0 && rdy0) begin
            acc0 <= acc0 + 1;
            ld0  <= d0;
            lfe0 <= fe0;
            lpe0 <= pe0;
        end
    end

    always @(negedge clk) begin
        if (v1) begin
            acc1 <= acc1 + 1;
            ld1  <= d1;
            lpe1 <= pe1;
        end
    end

    always @(negedge clk) begin
        if (v2) begin
            acc2 <= acc2 + 1;
            ld2  <= d2;
            lfe2 <= fe2;
            lpe2 <= pe2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns right after a clock edge on which the DUTs see sample_tick=1.
    task automatic wait_tick();
        do @(posedge clk); while (!sample_tick);
    endtask

    task automatic drive_bit(input int w, input logic b, input int nclk);
        #1 rx_line[w] = b;
        repeat (nclk) @(posedge clk);
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input int nb,
                              input bit pen, input bit pbit, input int nstop,
                              input bit stop_low, input int idle_bits);
        wait_tick();
        drive_bit(w, 1'b0, BIT_CLK);
        for (int i = 0; i < nb; i++) drive_bit(w, d[i], BIT_CLK);
        if (pen) drive_bit(w, pbit, BIT_CLK);
        for (int s = 0; s < nstop; s++) begin
            if (stop_low) begin
                drive_bit(w, 1'b0, BIT_CLK * 3 / 4);
                drive_bit(w, 1'b1, BIT_CLK / 4);
            end else begin
                drive_bit(w, 1'b1, BIT_CLK);
            end
        end
        drive_bit(w, 1'b1, idle_bits * BIT_CLK);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_data0", 32'(d0), 0);  chk("rst_valid0", 32'(v0), 0);
        chk("rst_fe0", 32'(fe0), 0);   chk("rst_pe0", 32'(pe0), 0);
        chk("rst_ov0", 32'(ov0), 0);
        chk("rst_data1", 32'(d1), 0);  chk("rst_valid1", 32'(v1), 0);
        chk("rst_flags1", 32'({fe1, pe1, ov1}), 0);
        chk("rst_data2", 32'(d2), 0);  chk("rst_valid2", 32'(v2), 0);
        chk("rst_flags2", 32'({fe2, pe2, ov2}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // Clean 8N1 frame, ready tied high: exactly one valid cycle.
        send_frame(0, 8'hA5, 8, 0, 0, 1, 0, 1);
        chk("a5_acc", 32'(acc0), 1);
        chk("a5_data", 32'(ld0), 32'hA5);
        chk("a5_flags", 32'({lfe0, lpe0}), 0);
        chk("a5_vcyc", 32'(vcyc0), 1);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right.
        send_frame(1, 8'h03, 8, 1, 1, 1, 0, 1);
        chk("par1_acc", 32'(acc1), 1);
        chk("par1_data", 32'(ld1), 32'h03);
        chk("par1_err", 32'(lpe1), 1);
        send_frame(1, 8'h03, 8, 1, 0, 1, 0, 1);
        chk("par0_acc", 32'(acc1), 2);
        chk("par0_err", 32'(lpe1), 0);

        // Low stop bit, then a clean frame clears the flag.
        send_frame(0, 8'h55, 8, 0, 0, 1, 1, 1);
        chk("fe_acc", 32'(acc0), 2);
        chk("fe_data", 32'(ld0), 32'h55);
        chk("fe_flag", 32'(lfe0), 1);
        send_frame(0, 8'h12, 8, 0, 0, 1, 0, 1);
        chk("clean_acc", 32'(acc0), 3);
        chk("clean_data", 32'(ld0), 32'h12);
        chk("clean_fe", 32'(lfe0), 0);

        // Overrun: consumer stalls across two back-to-back frames.
        @(negedge clk);
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 8, 0, 0, 1, 0, 0);
        chk("ovr_v_first", 32'(v0), 1);
        chk("ovr_d_first", 32'(d0), 32'h11);
        send_frame(0, 8'h22, 8, 0, 0, 1, 0, 1);
        chk("ovr_d_kept", 32'(d0), 32'h11);
        chk("ovr_v_kept", 32'(v0), 1);
        chk("ovr_pulses", 32'(ovc0), 1);
        chk("ovr_acc", 32'(acc0), 3);

        // Last stop mid-sample lands 153 ticks after the start-bit tick edge;
        // raise ready for exactly that edge so accept and commit coincide.
        fork
            send_frame(0, 8'h33, 8, 0, 0, 1, 0, 1);
            begin
                wait_tick();
                repeat (153 * TDIV - 1) @(posedge clk);
                #1 rdy0 = 1'b1;
            end
        join
        chk("sim_acc", 32'(acc0), 5);
        chk("sim_data", 32'(ld0), 32'h33);
        chk("sim_no_ovr", 32'(ovc0), 1);
        chk("sim_valid_clr", 32'(v0), 0);

        // Short low glitch is a false start; next frame still decodes.
        wait_tick();
        drive_bit(0, 1'b0, (OS / 4) * TDIV);
        drive_bit(0, 1'b1, 2 * BIT_CLK);
        chk("glitch_acc", 32'(acc0), 5);
        chk("glitch_valid", 32'(v0), 0);
        send_frame(0, 8'h7E, 8, 0, 0, 1, 0, 1);
        chk("7e_acc", 32'(acc0), 6);
        chk("7e_data", 32'(ld0), 32'h7E);
        chk("7e_fe", 32'(lfe0), 0);

        // 5N2: reset in the middle of the data bits discards the frame.
        fork
            send_frame(2, 8'h1F, 5, 0, 0, 2, 0, 1);
            begin
                wait_tick();
                repeat (2 * BIT_CLK + 20) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("mid_rst_data", 32'(d2), 0);
                chk("mid_rst_valid", 32'(v2), 0);
                chk("mid_rst_flags", 32'({fe2, pe2, ov2}), 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        chk("rst_drop_acc", 32'(acc2), 0);
        send_frame(2, 8'h0A, 5, 0, 0, 2, 0, 1);
        chk("5b_acc", 32'(acc2), 1);
        chk("5b_data", 32'(ld2), 32'h0A);
        chk("5b_flags", 32'({lfe2, lpe2}), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
